// File: rtl/dram_arbiter_ctrl_if.sv
// Client request/response and RAM pin bundle for dram_arbiter_ctrl.
// The controller takes the slave view; clients and RAM glue take the master view.
interface dram_arbiter_ctrl_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic              p0_valid;
  logic              p0_we;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic              p0_ready;
  logic              p0_rvalid;
  logic [DATA_W-1:0] p0_rdata;

  logic              p1_valid;
  logic              p1_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_ready;
  logic              p1_rvalid;
  logic [DATA_W-1:0] p1_rdata;

  logic              clear_start;
  logic              clear_busy;

  logic [ADDR_W-1:0] ram_a;
  logic [DATA_W-1:0] ram_d;
  logic              ram_we;
  logic [DATA_W-1:0] ram_o;

  modport slave (
    input  p0_valid, p0_we, p0_addr, p0_wdata,
    output p0_ready, p0_rvalid, p0_rdata,
    input  p1_valid, p1_we, p1_addr, p1_wdata,
    output p1_ready, p1_rvalid, p1_rdata,
    input  clear_start,
    output clear_busy,
    output ram_a, ram_d, ram_we,
    input  ram_o
  );

  modport master (
    output p0_valid, p0_we, p0_addr, p0_wdata,
    input  p0_ready, p0_rvalid, p0_rdata,
    output p1_valid, p1_we, p1_addr, p1_wdata,
    input  p1_ready, p1_rvalid, p1_rdata,
    output clear_start,
    input  clear_busy,
    input  ram_a, ram_d, ram_we,
    output ram_o
  );
endinterface

// File: rtl/dram_arbiter_ctrl.sv
// Round-robin two-port front end for a single-port distributed RAM,
// with a full-depth clear sweep after reset or on command.
module dram_arbiter_ctrl #(
  parameter int                ADDR_W         = 5,
  parameter int                DATA_W         = 8,
  parameter bit                CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_W-1:0] CLEAR_VALUE    = '0
) (
  input logic                clk,
  input logic                rst,
  dram_arbiter_ctrl_if.slave bus
);

  typedef enum logic {S_CLEAR = 1'b0, S_SERVE = 1'b1} state_t;

  localparam state_t            RST_STATE = CLEAR_ON_RESET ? S_CLEAR : S_SERVE;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_clr_addr, w_clr_addr_nxt;
  logic              r_last_grant, w_last_grant_nxt;
  logic              w_grant0, w_grant1;
  logic [ADDR_W-1:0] w_ram_a;
  logic [DATA_W-1:0] w_ram_d;
  logic              w_ram_we;
  logic              r_p0_rvalid, r_p1_rvalid;
  logic [DATA_W-1:0] r_p0_rdata, r_p1_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= RST_STATE;
      r_clr_addr   <= '0;
      r_last_grant <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_clr_addr   <= w_clr_addr_nxt;
      r_last_grant <= w_last_grant_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_clr_addr_nxt   = r_clr_addr;
    w_last_grant_nxt = r_last_grant;
    w_grant0         = 1'b0;
    w_grant1         = 1'b0;
    w_ram_a          = '0;
    w_ram_d          = '0;
    w_ram_we         = 1'b0;
    case (r_state)
      S_CLEAR: begin
        w_ram_a        = r_clr_addr;
        w_ram_d        = CLEAR_VALUE;
        w_ram_we       = 1'b1;
        w_clr_addr_nxt = r_clr_addr + 1'b1;
        if (r_clr_addr == LAST_ADDR) w_state_nxt = S_SERVE;
      end
      S_SERVE: begin
        // On conflict the port that did not win last time takes the slot.
        w_grant0 = bus.p0_valid && (!bus.p1_valid || r_last_grant);
        w_grant1 = bus.p1_valid && (!bus.p0_valid || !r_last_grant);
        if (w_grant0) begin
          w_ram_a          = bus.p0_addr;
          w_ram_d          = bus.p0_wdata;
          w_ram_we         = bus.p0_we;
          w_last_grant_nxt = 1'b0;
        end else if (w_grant1) begin
          w_ram_a          = bus.p1_addr;
          w_ram_d          = bus.p1_wdata;
          w_ram_we         = bus.p1_we;
          w_last_grant_nxt = 1'b1;
        end
        if (bus.clear_start) w_state_nxt = S_CLEAR;
      end
      default: w_state_nxt = RST_STATE;
    endcase
  end

  // Read data is taken from the asynchronous RAM output at the grant edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p0_rvalid <= 1'b0;
      r_p1_rvalid <= 1'b0;
      r_p0_rdata  <= '0;
      r_p1_rdata  <= '0;
    end else begin
      r_p0_rvalid <= w_grant0 && !bus.p0_we;
      r_p1_rvalid <= w_grant1 && !bus.p1_we;
      if (w_grant0 && !bus.p0_we) r_p0_rdata <= bus.ram_o;
      if (w_grant1 && !bus.p1_we) r_p1_rdata <= bus.ram_o;
    end
  end

  // Handshake and write strobe are held off while reset is asserted.
  assign bus.p0_ready   = w_grant0 && !rst;
  assign bus.p1_ready   = w_grant1 && !rst;
  assign bus.p0_rvalid  = r_p0_rvalid;
  assign bus.p1_rvalid  = r_p1_rvalid;
  assign bus.p0_rdata   = r_p0_rdata;
  assign bus.p1_rdata   = r_p1_rdata;
  assign bus.clear_busy = (r_state == S_CLEAR);
  assign bus.ram_a      = w_ram_a;
  assign bus.ram_d      = w_ram_d;
  assign bus.ram_we     = w_ram_we && !rst;

endmodule

// File: doc/dram_arbiter_ctrl.md
Name: dram_arbiter_ctrl

Overview:
- Controller that shares one single-port 32x8 distributed RAM (eight RAM32X1S bit-slices on common A[4:0]/WE/WCLK) between two requesters.
- Round-robin arbitration, one access per cycle.
- Includes a clear sequencer that sweeps every address after reset or on command.
- Sits between the RAM bit-slices and two client blocks. RAM primitives are instantiated outside this block; it drives their A/D/WE pins and reads their O pins.

Parameters:
- ADDR_W, 5, RAM address width (depth = 2^ADDR_W).
- DATA_W, 8, data width (number of 1-bit slices).
- CLEAR_ON_RESET, 1, 1 = run a clear sweep after reset release; 0 = go straight to SERVE.
- CLEAR_VALUE, 0, DATA_W-bit value written to every address during a sweep.

Ports:
- clk  in  1  single clock; also drives the RAM WCLK.
- rst  in  1  asynchronous, active-high reset.
- p0_valid  in  1  port 0 request.
- p0_we  in  1  port 0 write (1) / read (0).
- p0_addr  in  ADDR_W  port 0 address.
- p0_wdata  in  DATA_W  port 0 write data.
- p0_ready  out  1  port 0 request accepted this cycle.
- p0_rvalid  out  1  port 0 read data valid.
- p0_rdata  out  DATA_W  port 0 read data.
- p1_*  same set as p0_*, for port 1.
- clear_start  in  1  pulse that requests a clear sweep.
- clear_busy  out  1  sweep in progress.
- ram_a  out  ADDR_W  to the A[ADDR_W-1:0] pins of all slices.
- ram_d  out  DATA_W  bit i to D of slice i.
- ram_we  out  1  to WE of all slices.
- ram_o  in  DATA_W  bit i from O of slice i (asynchronous read).

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - state = CLEAR if CLEAR_ON_RESET, else SERVE.
  - clr_addr = 0; last_grant = 1, so port 0 wins the first conflict.
  - pX_rvalid = 0, pX_rdata = 0, clear_busy = CLEAR_ON_RESET.
  - pX_ready = 0 while in reset.
- FSM states: CLEAR, SERVE.
- CLEAR:
  - Each cycle drives ram_a = clr_addr, ram_d = CLEAR_VALUE, ram_we = 1, then increments clr_addr.
  - After writing address 2^ADDR_W-1: clr_addr wraps to 0 and the FSM moves to SERVE.
  - A sweep is exactly 2^ADDR_W cycles. clear_busy = 1 throughout.
  - Both pX_ready = 0. clear_start is ignored.
  - Reset mid-sweep restarts the sweep from address 0.
- SERVE:
  - clear_start = 1 moves to CLEAR next cycle. In that cycle a request can still be granted.
  - Requests and grant:
    - Grant is combinational. pX_ready = 1 only for the winner, and only if pX_valid = 1.
    - Only one valid: that port wins.
    - Both valid: the port not equal to last_grant wins.
    - last_grant updates to the winner on every grant.
    - No valid: ram_we = 0, last_grant unchanged.
  - Granted access:
    - ram_a = winner addr. ram_d = winner wdata. ram_we = winner we.
    - Write commits at the next rising edge of clk.
  - Read (we = 0):
    - ram_o is captured into pX_rdata at the grant edge.
    - pX_rvalid = 1 for exactly one cycle, the cycle after acceptance.
    - Latency = 1 cycle.
  - Write: no rvalid pulse. pX_rdata holds its previous value.
  - Back-to-back reads on one port give one rvalid pulse per accepted read.
  - Read of an address written in the previous cycle returns the new data.
  - The loser holds its request. valid/addr/we/wdata must stay stable until ready; the loser is granted the next cycle it competes.
- No internal queueing. The ready/valid handshake is the only flow control. rvalid has no backpressure.

Test Plan:
- Reset with CLEAR_ON_RESET=1 and preloaded RAM INIT=32'h2 on all slices -> clear_busy = 1 for 32 cycles, ram_we = 1 with ram_a = 0..31; afterwards a read of address 1 returns 8'h00.
- Port 0 writes 8'hA5 to address 3, then reads address 3 the next cycle -> p0_ready = 1 both cycles; p0_rvalid one cycle after the read with p0_rdata = 8'hA5.
- Both ports hold a read continuously (p0 address 4, p1 address 5) -> grants alternate p0, p1, p0, p1; port 0 first after reset; each port gets rvalid every other cycle.
- Port 1 writes 8'h3C to address 31 while port 0 is idle, then clear_start is pulsed -> port 1 is granted in the pulse cycle; the 32-cycle sweep follows with both ready = 0; a read of address 31 afterwards returns CLEAR_VALUE.
- rst asserted at sweep address 10 and released -> the sweep restarts at address 0 and completes all 32 addresses.
- Port 0 writes 8'hFF to address 0; port 1 reads address 0 in the next cycle -> p1_rdata = 8'hFF; p0_rvalid stays 0 throughout.
